// File: rtl/vga_timing_pipe_pkg.sv
// Shared VGA types: colour word, timing record and the two standard modes.
package vga_timing_pipe_pkg;

  typedef logic [11:0] color;

  typedef struct packed {
    logic [15:0] h_size;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_size;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640x480_60 = '{
    h_size: 16'd640, h_fp: 16'd16, h_sync: 16'd96,  h_bp: 16'd48,
    v_size: 16'd480, v_fp: 16'd10, v_sync: 16'd2,   v_bp: 16'd33
  };

  localparam vga_timing_t VGA_800x600_72 = '{
    h_size: 16'd800, h_fp: 16'd56, h_sync: 16'd120, h_bp: 16'd64,
    v_size: 16'd600, v_fp: 16'd37, v_sync: 16'd6,   v_bp: 16'd23
  };

  // Control bundle carried through the delay line: {line, frame, vs, hs, visible}
  localparam int CTRL_W = 5;

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with asynchronous clear; DEPTH=0 is a plain wire.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             pixelclk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{pixelclk, rst_n, en};
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge pixelclk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (en) begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_pipe.sv
// VGA timing generator issuing pixel requests LATENCY enabled cycles ahead of
// the aligned colour, sync, data-enable and frame/line markers.
module vga_timing_pipe
  import vga_timing_pipe_pkg::*;
#(
  parameter int H_SIZE    = 800,
  parameter int V_SIZE    = 600,
  parameter int H_FP      = 56,
  parameter int H_SYNC    = 120,
  parameter int H_BP      = 64,
  parameter int V_FP      = 37,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 23,
  parameter int HSYNC_POL = 1,
  parameter int VSYNC_POL = 1,
  parameter int LATENCY   = 2
) (
  input  logic                      pixelclk,
  input  logic                      rst_n,
  input  logic                      en,
  input  color                      color_in,
  output logic [$clog2(H_SIZE)-1:0] pix_x,
  output logic [$clog2(V_SIZE)-1:0] pix_y,
  output logic                      pix_valid,
  output color                      color_out,
  output logic                      vga_de,
  output logic                      vga_hsync,
  output logic                      vga_vsync,
  output logic                      frame_start,
  output logic                      line_start
);

  localparam int H_TOTAL = H_SIZE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_SIZE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = $clog2(H_SIZE);
  localparam int YW = $clog2(V_SIZE);

  // Inclusive end points avoid overflow when a back porch is zero.
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS   = HW'(H_SIZE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_SIZE + H_FP);
  localparam logic [HW-1:0] HS_LAST = HW'(H_SIZE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS   = VW'(V_SIZE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_SIZE + V_FP);
  localparam logic [VW-1:0] VS_LAST = VW'(V_SIZE + V_FP + V_SYNC - 1);
  localparam bit HPOL = (HSYNC_POL != 0);
  localparam bit VPOL = (VSYNC_POL != 0);

  if (H_SYNC == 0 || V_SYNC == 0 || LATENCY < 0 || LATENCY > 15) begin : g_bad_cfg
    $error("vga_timing_pipe: H_SYNC/V_SYNC must be nonzero and LATENCY within 0..15");
  end

  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic              visible, hs_raw, vs_raw, frame_mk, line_mk;
  logic [CTRL_W-1:0] ctrl_p0, ctrl_p1;

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  always_comb begin
    visible  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hs_raw   = (h_cnt >= HS_BEG) && (h_cnt <= HS_LAST);
    vs_raw   = (v_cnt >= VS_BEG) && (v_cnt <= VS_LAST);
    frame_mk = (h_cnt == '0) && (v_cnt == '0);
    line_mk  = (h_cnt == '0) && (v_cnt < V_VIS);
  end

  // Stage p0: request registers, control bundle aligned with the request.
  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      ctrl_p0   <= '0;
    end else if (en) begin
      pix_valid <= visible;
      pix_x     <= visible ? h_cnt[XW-1:0] : '0;
      pix_y     <= visible ? v_cnt[YW-1:0] : '0;
      ctrl_p0   <= {line_mk, frame_mk, vs_raw, hs_raw, visible};
    end
  end

  // Stage p1: control delayed to meet colour returning from the pixel source.
  vga_delay_line #(
    .WIDTH(CTRL_W),
    .DEPTH(LATENCY)
  ) u_ctrl_dly (
    .pixelclk(pixelclk),
    .rst_n   (rst_n),
    .en      (en),
    .din     (ctrl_p0),
    .dout    (ctrl_p1)
  );

  // Stage p2: output register toward the DAC and sync pins.
  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      vga_de      <= 1'b0;
      color_out   <= '0;
      vga_hsync   <= ~HPOL;
      vga_vsync   <= ~VPOL;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else if (en) begin
      vga_de      <= ctrl_p1[0];
      color_out   <= ctrl_p1[0] ? color_in : '0;
      vga_hsync   <= ~(ctrl_p1[1] ^ HPOL);
      vga_vsync   <= ~(ctrl_p1[2] ^ VPOL);
      frame_start <= ctrl_p1[3];
      line_start  <= ctrl_p1[4];
    end
  end

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Bench for vga_timing_pipe: default 800x600 instance and a small active-low,
// zero-latency instance, checked against a scoreboard of expected outputs.
module tb_vga_timing_pipe;
  import vga_timing_pipe_pkg::*;

  typedef struct {
    int h_size, h_fp, h_sync, h_bp, v_size, v_fp, v_sync, v_bp, ph, pv, lat;
  } cfg_t;

  typedef struct {
    bit vis, hs, vs, fs, ls;
    int h, v;
  } rec_t;

  logic pixelclk = 1'b0;
  logic rst_n_a = 1'b0, rst_n_b = 1'b0, en = 1'b0;
  color color_in = '0;

  logic [9:0] a_x, a_y;
  logic       a_valid, a_de, a_hs, a_vs, a_fs, a_ls;
  color       a_col;
  logic [3:0] b_x;
  logic [2:0] b_y;
  logic       b_valid, b_de, b_hs, b_vs, b_fs, b_ls;
  color       b_col;

  vga_timing_pipe dut_a (
    .pixelclk(pixelclk), .rst_n(rst_n_a), .en(en), .color_in(color_in),
    .pix_x(a_x), .pix_y(a_y), .pix_valid(a_valid), .color_out(a_col),
    .vga_de(a_de), .vga_hsync(a_hs), .vga_vsync(a_vs),
    .frame_start(a_fs), .line_start(a_ls)
  );

  vga_timing_pipe #(
    .H_SIZE(16), .V_SIZE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_FP(1), .V_SYNC(2), .V_BP(1), .HSYNC_POL(0), .VSYNC_POL(0), .LATENCY(0)
  ) dut_b (
    .pixelclk(pixelclk), .rst_n(rst_n_b), .en(en), .color_in(color_in),
    .pix_x(b_x), .pix_y(b_y), .pix_valid(b_valid), .color_out(b_col),
    .vga_de(b_de), .vga_hsync(b_hs), .vga_vsync(b_vs),
    .frame_start(b_fs), .line_start(b_ls)
  );

  always #5 pixelclk = ~pixelclk;

  bit          sel;
  logic [15:0] o_x, o_y;
  logic        o_valid, o_de, o_hs, o_vs, o_fs, o_ls;
  color        o_col;
  logic [16:0] o_out;

  assign o_x     = sel ? 16'(b_x) : 16'(a_x);
  assign o_y     = sel ? 16'(b_y) : 16'(a_y);
  assign o_valid = sel ? b_valid : a_valid;
  assign o_de    = sel ? b_de : a_de;
  assign o_hs    = sel ? b_hs : a_hs;
  assign o_vs    = sel ? b_vs : a_vs;
  assign o_fs    = sel ? b_fs : a_fs;
  assign o_ls    = sel ? b_ls : a_ls;
  assign o_col   = sel ? b_col : a_col;
  assign o_out   = {o_de, o_hs, o_vs, o_fs, o_ls, o_col};

  int errors = 0;
  int checks = 0;

  cfg_t        cfg;
  rec_t        sbq[$];
  rec_t        exp_req;
  logic [16:0] exp_out;
  int          n_req, clk_cnt;
  bit          all_ones;

  int hs_on, hs_on1, hs_w, hs_per, vs_on, vs_on1, vs_w, vs_per;
  int fs_clk, de_clk, blank_bad, trail_err;
  logic prev_hs, prev_vs, prev_valid;

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic rec_t model(input int n);
    rec_t r;
    int ht, vt;
    ht = cfg.h_size + cfg.h_fp + cfg.h_sync + cfg.h_bp;
    vt = cfg.v_size + cfg.v_fp + cfg.v_sync + cfg.v_bp;
    r.h   = n % ht;
    r.v   = (n / ht) % vt;
    r.vis = (r.h < cfg.h_size) && (r.v < cfg.v_size);
    r.hs  = (r.h >= cfg.h_size + cfg.h_fp) && (r.h < cfg.h_size + cfg.h_fp + cfg.h_sync);
    r.vs  = (r.v >= cfg.v_size + cfg.v_fp) && (r.v < cfg.v_size + cfg.v_fp + cfg.v_sync);
    r.fs  = (r.h == 0) && (r.v == 0);
    r.ls  = (r.h == 0) && (r.v < cfg.v_size);
    return r;
  endfunction

  function automatic logic [32:0] req_vec(input rec_t r);
    return {r.vis, r.vis ? 16'(r.h) : 16'h0, r.vis ? 16'(r.v) : 16'h0};
  endfunction

  task automatic clear_monitors();
    hs_on = -1; hs_on1 = -1; hs_w = 0; hs_per = 0;
    vs_on = -1; vs_on1 = -1; vs_w = 0; vs_per = 0;
    fs_clk = -1; de_clk = -1; blank_bad = 0; trail_err = 0;
  endtask

  task automatic start_phase(input bit s, input cfg_t c);
    rec_t idle;
    idle = '{vis: 0, hs: 0, vs: 0, fs: 0, ls: 0, h: 0, v: 0};
    @(negedge pixelclk);
    sel = s;
    cfg = c;
    en  = 1'b1;
    if (s) rst_n_b = 1'b0; else rst_n_a = 1'b0;
    sbq.delete();
    for (int i = 0; i <= c.lat; i++) sbq.push_back(idle);
    n_req   = 0;
    exp_req = idle;
    exp_out = {1'b0, ~c.ph[0], ~c.pv[0], 2'b00, 12'h000};
    @(negedge pixelclk);
    chk("rst_out", 64'(o_out), 64'(exp_out));
    chk("rst_req", 64'({o_valid, o_x, o_y}), 64'(0));
    if (s) rst_n_b = 1'b1; else rst_n_a = 1'b1;
    clear_monitors();
    prev_hs = o_hs; prev_vs = o_vs; prev_valid = o_valid;
  endtask

  task automatic step(input bit e);
    rec_t o;
    en       = e;
    color_in = all_ones ? 12'hFFF : 12'($urandom);
    @(posedge pixelclk);
    clk_cnt++;
    if (e) begin
      exp_req = model(n_req);
      n_req++;
      sbq.push_back(exp_req);
      o = sbq.pop_front();
      exp_out = {o.vis, o.hs ~^ cfg.ph[0], o.vs ~^ cfg.pv[0], o.fs, o.ls,
                 o.vis ? color_in : 12'h000};
    end
    @(negedge pixelclk);
    chk("req", 64'({o_valid, o_x, o_y}), 64'(req_vec(exp_req)));
    chk("out", 64'(o_out), 64'(exp_out));
    if (o_hs != prev_hs) begin
      if (o_hs == cfg.ph[0]) begin
        if (hs_on1 < 0) hs_on1 = clk_cnt;
        if (hs_on >= 0) hs_per = clk_cnt - hs_on;
        hs_on = clk_cnt;
      end else if (hs_on >= 0) hs_w = clk_cnt - hs_on;
    end
    if (o_vs != prev_vs) begin
      if (o_vs == cfg.pv[0]) begin
        if (vs_on1 < 0) vs_on1 = clk_cnt;
        if (vs_on >= 0) vs_per = clk_cnt - vs_on;
        vs_on = clk_cnt;
      end else if (vs_on >= 0) vs_w = clk_cnt - vs_on;
    end
    if (o_fs && fs_clk < 0) fs_clk = clk_cnt;
    if (o_de && de_clk < 0) de_clk = clk_cnt;
    if (all_ones && (o_de ? (o_col != 12'hFFF) : (o_col != 12'h000))) blank_bad++;
    if (sel && (o_de != prev_valid)) trail_err++;
    prev_hs = o_hs; prev_vs = o_vs; prev_valid = o_valid;
  endtask

  initial begin
    cfg_t cfg_a, cfg_b;
    int   first_clk;
    bit   found;
    cfg_a = '{800, 56, 120, 64, 600, 37, 6, 23, 1, 1, 2};
    cfg_b = '{16, 2, 3, 3, 8, 1, 2, 1, 0, 0, 0};
    clk_cnt = 0;
    sel = 1'b0;
    cfg = cfg_a;

    // Default mode at full rate with constant white colour.
    all_ones = 1'b1;
    start_phase(1'b0, cfg_a);
    step(1'b1);
    first_clk = clk_cnt;
    chk("first_req", 64'({o_valid, o_x, o_y}), 64'({1'b1, 32'h0}));
    repeat (3200) step(1'b1);
    chk("fs_latency", fs_clk - first_clk, 3);
    chk("de_latency", de_clk - first_clk, 3);
    chk("hs_width", hs_w, 120);
    chk("hs_period", hs_per, 1040);
    chk("hs_offset", hs_on1 - fs_clk, 856);
    chk("blank_colour", blank_bad, 0);

    // Same instance with en asserted one cycle in four.
    all_ones = 1'b0;
    clear_monitors();
    repeat (2400) begin
      step(1'b1);
      repeat (3) step(1'b0);
    end
    chk("hs_period_en4", hs_per, 4160);
    chk("hs_width_en4", hs_w, 480);

    // Small active-low, zero-latency instance over two frames.
    start_phase(1'b1, cfg_b);
    repeat (700) step(1'b1);
    chk("hs_width_b", hs_w, 3);
    chk("hs_period_b", hs_per, 24);
    chk("vs_width_b", vs_w, 48);
    chk("vs_period_b", vs_per, 288);
    chk("vs_offset_b", vs_on1 - fs_clk, 216);
    chk("de_trails_valid", trail_err, 0);

    // Asynchronous reset while both syncs are in their active (low) state.
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      step(1'b1);
      if (!o_hs && !o_vs) found = 1'b1;
    end
    chk("sync_active_seen", 64'(found), 64'(1));
    #2 rst_n_b = 1'b0;
    #1 chk("async_reset", 64'({o_out, o_valid}), 64'({1'b0, 1'b1, 1'b1, 2'b00, 12'h000, 1'b0}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
